// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage types: operand width, divide op and divider FSM encodings.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {DIV_S, DIV_U, REM_S, REM_U} div_op_e;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

  function automatic logic is_rem(input div_op_e op);
    return (op == REM_S) || (op == REM_U);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The XLEN+1-bit compare keeps the bit shifted out of rem, so no overflow near 2^XLEN.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/rv_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with valid/ready request and result channels.
module rv_div_unit #(
  parameter int unsigned XLEN = rv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      funct_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);
  import rv_pkg::*;

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_e      state, state_next;
  div_op_e         op_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] dvd, dvs, rem, quo;
  logic [CNT_W-1:0] cnt;

  logic            accept, is_signed, op1_neg, op2_neg, div_zero, ovf, fast, last_iter;
  logic [XLEN-1:0] op1_mag, op2_mag, rem_step, fix_res;
  logic            q_bit;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[XLEN-1]),
    .dvs      (dvs),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  always_comb begin
    accept    = req_valid_i && (state == DIV_IDLE);
    is_signed = ~funct_i[0];
    op1_neg   = is_signed & op1_i[XLEN-1];
    op2_neg   = is_signed & op2_i[XLEN-1];
    op1_mag   = op1_neg ? -op1_i : op1_i;
    op2_mag   = op2_neg ? -op2_i : op2_i;
    div_zero  = (op2_i == '0);
    ovf       = is_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    fast      = div_zero || ovf;
    last_iter = (cnt == CNT_W'(XLEN-1));
    if (is_rem(op_q)) fix_res = neg_r ? -rem : rem;
    else              fix_res = neg_q ? -quo : quo;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (accept) state_next = fast ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (last_iter) state_next = DIV_DONE;
      DIV_DONE: if (res_valid_o && res_ready_i) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q        <= DIV_S;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: if (accept) begin
          op_q <= div_op_e'(funct_i);
          cnt  <= '0;
          // Fast-path results are preloaded raw with sign fix-up disabled.
          if (div_zero) begin
            quo   <= '1;
            rem   <= op1_i;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else if (ovf) begin
            quo   <= {1'b1, {(XLEN-1){1'b0}}};
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            dvd   <= op1_mag;
            dvs   <= op2_mag;
            rem   <= '0;
            quo   <= '0;
            neg_q <= op1_neg ^ op2_neg;
            neg_r <= op1_neg;
          end
        end
        DIV_CALC: begin
          rem <= rem_step;
          dvd <= {dvd[XLEN-2:0], 1'b0};
          quo <= {quo[XLEN-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
        end
        DIV_DONE: begin
          if (!res_valid_o) begin
            res_valid_o <= 1'b1;
            res_o       <= fix_res;
          end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state == DIV_IDLE);
  assign busy_o      = (state != DIV_IDLE);

endmodule
